uart_command_arbiter: RTL and testbench

//  Shares one downstream command consumer between two uart_command_accumulator instances: ch0 = BLE side, ch1 = host side.

---
 rtl/uart_cmd_pkg.sv | 35 +++
 rtl/uart_done_tracker.sv | 72 +++++++
 rtl/uart_command_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_command_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command arbiter: default widths, FSM
// encoding, channel source identifiers and the grant selection helper.
package uart_cmd_pkg;

  localparam int DATA_W_DEF = 1024;
  localparam int SIZE_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

  // Source identifiers reported on cmd_source
  localparam logic SRC_BLE  = 1'b0;
  localparam logic SRC_HOST = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    PRESENT = 2'd2
  } arb_state_t;

  // Pick the channel to serve from the pending mask. A lone pending channel
  // always wins; a tie goes to the round-robin pointer unless fixed priority
  // is selected, in which case the BLE side wins.
  function automatic logic select_grant(input logic [1:0] pend,
                                        input logic       rr_ptr,
                                        input logic       fixed_prio);
    logic pick;
    case (pend)
      2'b01:   pick = SRC_BLE;
      2'b10:   pick = SRC_HOST;
      2'b11:   pick = fixed_prio ? SRC_BLE : rr_ptr;
      default: pick = SRC_BLE;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/uart_done_tracker.sv
// Per-channel completion tracker: detects the rising edge of an accumulator's
// done flag, keeps a pending request for the arbiter, and counts error
// completions and frames overwritten before they could be granted.
module uart_done_tracker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             done,
  input  logic             error,
  input  logic             enable,
  input  logic             clear_pending,
  output logic             pending,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] ovr_count
);

  logic done_q;
  logic completion;
  logic set_pending;
  logic err_hit;
  logic ovr_hit;

  // Classify this cycle's completion; a set coinciding with the arbiter's
  // clear is not an overrun because the older frame was just taken.
  always_comb begin
    completion  = done & ~done_q;
    set_pending = enable & completion & ~error;
    err_hit     = enable & completion & error;
    ovr_hit     = set_pending & pending & ~clear_pending;
  end

  // Done history; starts high because accumulators hold done=1 out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b1;
    end else begin
      done_q <= done;
    end
  end

  // Pending request: disable wins, then a new frame, then the arbiter's clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (!enable) begin
      pending <= 1'b0;
    end else if (set_pending) begin
      pending <= 1'b1;
    end else if (clear_pending) begin
      pending <= 1'b0;
    end else begin
      pending <= pending;
    end
  end

  // Saturating status counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= {CNT_W{1'b0}};
      ovr_count <= {CNT_W{1'b0}};
    end else begin
      if (err_hit && (err_count != {CNT_W{1'b1}})) begin
        err_count <= err_count + CNT_W'(1);
      end
      if (ovr_hit && (ovr_count != {CNT_W{1'b1}})) begin
        ovr_count <= ovr_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_command_arbiter.sv
// Shares one command consumer between the BLE (ch0) and host (ch1) command
// accumulators. Completed frames are granted round-robin (or fixed priority),
// captured into a single output register and held on a valid/ready handshake.
module uart_command_arbiter
  import uart_cmd_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int SIZE_W         = SIZE_W_DEF,
  parameter int CNT_W          = CNT_W_DEF,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ch0_data,
  input  logic [SIZE_W-1:0] ch0_size,
  input  logic              ch0_done,
  input  logic              ch0_error,
  input  logic [DATA_W-1:0] ch1_data,
  input  logic [SIZE_W-1:0] ch1_size,
  input  logic              ch1_done,
  input  logic              ch1_error,
  input  logic [1:0]        ch_enable,
  input  logic              cmd_ready,
  output logic              cmd_valid,
  output logic [DATA_W-1:0] cmd_data,
  output logic [SIZE_W-1:0] cmd_size,
  output logic              cmd_source,
  output logic [CNT_W-1:0]  err_count0,
  output logic [CNT_W-1:0]  err_count1,
  output logic [CNT_W-1:0]  ovr_count0,
  output logic [CNT_W-1:0]  ovr_count1
);

  arb_state_t state;
  arb_state_t state_next;
  logic       grant;
  logic       rr_ptr;
  logic       pick;
  logic [1:0] pending;
  logic [1:0] clear_pending;
  logic       load_grant;
  logic       capture;
  logic       handshake;

  uart_done_tracker #(.CNT_W(CNT_W)) u_track_ble (
    .clk           (clk),
    .reset         (reset),
    .done          (ch0_done),
    .error         (ch0_error),
    .enable        (ch_enable[0]),
    .clear_pending (clear_pending[0]),
    .pending       (pending[0]),
    .err_count     (err_count0),
    .ovr_count     (ovr_count0)
  );

  uart_done_tracker #(.CNT_W(CNT_W)) u_track_host (
    .clk           (clk),
    .reset         (reset),
    .done          (ch1_done),
    .error         (ch1_error),
    .enable        (ch_enable[1]),
    .clear_pending (clear_pending[1]),
    .pending       (pending[1]),
    .err_count     (err_count1),
    .ovr_count     (ovr_count1)
  );

  // Candidate grant for the next capture
  always_comb begin
    pick = select_grant(pending, rr_ptr, FIXED_PRIORITY != 0);
  end

  // FSM next state and per-state strobes
  always_comb begin
    state_next    = state;
    load_grant    = 1'b0;
    capture       = 1'b0;
    handshake     = 1'b0;
    clear_pending = 2'b00;
    case (state)
      IDLE: begin
        if (|pending) begin
          load_grant = 1'b1;
          state_next = CAPTURE;
        end else begin
          state_next = IDLE;
        end
      end
      CAPTURE: begin
        capture       = 1'b1;
        clear_pending = (grant == SRC_HOST) ? 2'b10 : 2'b01;
        state_next    = PRESENT;
      end
      PRESENT: begin
        if (cmd_valid && cmd_ready) begin
          handshake  = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = PRESENT;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant latch and round-robin pointer; the pointer moves past the channel
  // just served once its command is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant  <= SRC_BLE;
      rr_ptr <= SRC_BLE;
    end else begin
      if (load_grant) begin
        grant <= pick;
      end
      if (handshake) begin
        rr_ptr <= ~grant;
      end
    end
  end

  // Output command register: captured once, held until accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_valid  <= 1'b0;
      cmd_data   <= {DATA_W{1'b0}};
      cmd_size   <= {SIZE_W{1'b0}};
      cmd_source <= SRC_BLE;
    end else if (capture) begin
      cmd_valid  <= 1'b1;
      cmd_data   <= (grant == SRC_HOST) ? ch1_data : ch0_data;
      cmd_size   <= (grant == SRC_HOST) ? ch1_size : ch0_size;
      cmd_source <= grant;
    end else if (handshake) begin
      cmd_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_command_arbiter.sv
// Bench for uart_command_arbiter: two instances (round-robin with 8-bit
// counters, fixed priority with 2-bit counters) share one stimulus and are
// compared every cycle against a behavioural model, plus directed scenarios.
module tb_uart_command_arbiter;

  localparam int DW = 1024;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data [2];
  logic [SW-1:0] size [2];
  logic [1:0]    done;
  logic [1:0]    error;
  logic [1:0]    ch_enable;
  logic          cmd_ready;

  logic          a_valid, a_src, b_valid, b_src;
  logic [DW-1:0] a_data, b_data;
  logic [SW-1:0] a_size, b_size;
  logic [7:0]    a_err0, a_err1, a_ovr0, a_ovr1;
  logic [1:0]    b_err0, b_err1, b_ovr0, b_ovr1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_command_arbiter #(.DATA_W(DW), .SIZE_W(SW), .CNT_W(8), .FIXED_PRIORITY(0)) dut_a (
    .clk(clk), .reset(reset),
    .ch0_data(data[0]), .ch0_size(size[0]), .ch0_done(done[0]), .ch0_error(error[0]),
    .ch1_data(data[1]), .ch1_size(size[1]), .ch1_done(done[1]), .ch1_error(error[1]),
    .ch_enable(ch_enable), .cmd_ready(cmd_ready),
    .cmd_valid(a_valid), .cmd_data(a_data), .cmd_size(a_size), .cmd_source(a_src),
    .err_count0(a_err0), .err_count1(a_err1), .ovr_count0(a_ovr0), .ovr_count1(a_ovr1)
  );

  uart_command_arbiter #(.DATA_W(DW), .SIZE_W(SW), .CNT_W(2), .FIXED_PRIORITY(1)) dut_b (
    .clk(clk), .reset(reset),
    .ch0_data(data[0]), .ch0_size(size[0]), .ch0_done(done[0]), .ch0_error(error[0]),
    .ch1_data(data[1]), .ch1_size(size[1]), .ch1_done(done[1]), .ch1_error(error[1]),
    .ch_enable(ch_enable), .cmd_ready(cmd_ready),
    .cmd_valid(b_valid), .cmd_data(b_data), .cmd_size(b_size), .cmd_source(b_src),
    .err_count0(b_err0), .err_count1(b_err1), .ovr_count0(b_ovr0), .ovr_count1(b_ovr1)
  );

  // ---------------- behavioural model (index 0 = dut_a, 1 = dut_b) ----------
  logic [1:0]    m_prev  [2];
  logic [1:0]    m_pend  [2];
  int            m_err   [2][2];
  int            m_ovr   [2][2];
  int            m_phase [2];   // 0 waiting, 1 about to capture, 2 holding
  logic          m_gnt   [2];
  logic          m_rr    [2];
  logic          m_valid [2];
  logic [DW-1:0] m_data  [2];
  logic [SW-1:0] m_size  [2];
  logic          m_src   [2];

  task automatic model_reset(input int i);
    m_prev[i]  = 2'b11;
    m_pend[i]  = 2'b00;
    for (int c = 0; c < 2; c++) begin
      m_err[i][c] = 0;
      m_ovr[i][c] = 0;
    end
    m_phase[i] = 0;
    m_gnt[i]   = 1'b0;
    m_rr[i]    = 1'b0;
    m_valid[i] = 1'b0;
    m_data[i]  = '0;
    m_size[i]  = '0;
    m_src[i]   = 1'b0;
  endtask

  task automatic model_step(input int i);
    logic [1:0] pend_before;
    int         cmax;
    logic       ev;
    logic       taken;
    cmax        = (i == 0) ? 255 : 3;
    pend_before = m_pend[i];
    for (int c = 0; c < 2; c++) begin
      ev    = done[c] && !m_prev[i][c];
      taken = (m_phase[i] == 1) && (m_gnt[i] == 1'(c));
      if (!ch_enable[c]) begin
        m_pend[i][c] = 1'b0;
      end else begin
        if (ev && error[c] && m_err[i][c] < cmax) m_err[i][c] = m_err[i][c] + 1;
        if (ev && !error[c]) begin
          if (m_pend[i][c] && !taken && m_ovr[i][c] < cmax) m_ovr[i][c] = m_ovr[i][c] + 1;
          m_pend[i][c] = 1'b1;
        end else if (taken) begin
          m_pend[i][c] = 1'b0;
        end
      end
      m_prev[i][c] = done[c];
    end
    case (m_phase[i])
      0: if (pend_before != 2'b00) begin
        if (pend_before == 2'b11) m_gnt[i] = (i == 1) ? 1'b0 : m_rr[i];
        else                      m_gnt[i] = pend_before[1];
        m_phase[i] = 1;
      end
      1: begin
        m_data[i]  = data[m_gnt[i]];
        m_size[i]  = size[m_gnt[i]];
        m_src[i]   = m_gnt[i];
        m_valid[i] = 1'b1;
        m_phase[i] = 2;
      end
      default: if (cmd_ready) begin
        m_valid[i] = 1'b0;
        m_rr[i]    = !m_gnt[i];
        m_phase[i] = 0;
      end
    endcase
  endtask

  // Advance the model on every clock edge, or return it to reset state
  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) model_reset(i);
      else       model_step(i);
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fold(input logic [DW-1:0] v);
    logic [63:0] f;
    f = 64'd0;
    for (int w = 0; w < DW / 64; w++) f = f ^ v[w*64 +: 64];
    return f;
  endfunction

  function automatic logic [DW-1:0] rand_wide();
    logic [DW-1:0] v;
    for (int w = 0; w < DW / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic compare_all();
    check_value("a_valid",  64'(a_valid),    64'(m_valid[0]));
    check_value("a_src",    64'(a_src),      64'(m_src[0]));
    check_value("a_size",   64'(a_size),     64'(m_size[0]));
    check_value("a_dlo",    a_data[63:0],    m_data[0][63:0]);
    check_value("a_dfold",  fold(a_data),    fold(m_data[0]));
    check_value("a_err0",   64'(a_err0),     64'(m_err[0][0]));
    check_value("a_err1",   64'(a_err1),     64'(m_err[0][1]));
    check_value("a_ovr0",   64'(a_ovr0),     64'(m_ovr[0][0]));
    check_value("a_ovr1",   64'(a_ovr1),     64'(m_ovr[0][1]));
    check_value("b_valid",  64'(b_valid),    64'(m_valid[1]));
    check_value("b_src",    64'(b_src),      64'(m_src[1]));
    check_value("b_size",   64'(b_size),     64'(m_size[1]));
    check_value("b_dfold",  fold(b_data),    fold(m_data[1]));
    check_value("b_err0",   64'(b_err0),     64'(m_err[1][0]));
    check_value("b_err1",   64'(b_err1),     64'(m_err[1][1]));
    check_value("b_ovr0",   64'(b_ovr0),     64'(m_ovr[1][0]));
    check_value("b_ovr1",   64'(b_ovr1),     64'(m_ovr[1][1]));
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  // Drop done for one cycle, then raise it with a fresh frame (no tick after)
  task automatic complete(input int c, input logic err, input logic [7:0] sz, input logic [7:0] lsb);
    done[c] = 1'b0;
    tick();
    data[c]       = rand_wide();
    data[c][7:0]  = lsb;
    size[c]       = sz;
    error[c]      = err;
    done[c]       = 1'b1;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check_value("rst_valid_a", 64'(a_valid), 64'd0);
    check_value("rst_valid_b", 64'(b_valid), 64'd0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Wait (bounded) for a presented command and check both sources
  task automatic wait_cmd(input string tag, input logic exp_a, input logic exp_b);
    int n;
    n = 0;
    while (!a_valid && n < 30) begin
      tick();
      n++;
    end
    check_value({tag, "_seen"},  64'(a_valid), 64'd1);
    check_value({tag, "_seenb"}, 64'(b_valid), 64'd1);
    check_value({tag, "_src_a"}, 64'(a_src),   64'(exp_a));
    check_value({tag, "_src_b"}, 64'(b_src),   64'(exp_b));
  endtask

  logic [DW-1:0] frame2;
  int            seen_ble;

  initial begin
    reset     = 1'b1;
    done      = 2'b11;
    error     = 2'b00;
    ch_enable = 2'b11;
    cmd_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      data[c] = '0;
      size[c] = '0;
    end
    tick();
    tick();
    reset = 1'b0;

    // 1: reset release with done held high produces nothing
    for (int k = 0; k < 20; k++) begin
      tick();
      check_value("t1_valid", 64'(a_valid), 64'd0);
    end
    check_value("t1_err0", 64'(a_err0), 64'd0);
    check_value("t1_ovr1", 64'(a_ovr1), 64'd0);

    // 2: single ch0 frame, cmd_valid from the third edge after the done rise
    cmd_ready = 1'b1;
    complete(0, 1'b0, 8'h05, 8'hA1);
    tick();
    check_value("t2_cyc1", 64'(a_valid), 64'd0);
    tick();
    check_value("t2_cyc2", 64'(a_valid), 64'd0);
    tick();
    check_value("t2_valid", 64'(a_valid), 64'd1);
    check_value("t2_src",   64'(a_src),   64'd0);
    check_value("t2_size",  64'(a_size),  64'd5);
    check_value("t2_lsb",   64'(a_data[7:0]), 64'hA1);
    tick();
    check_value("t2_drop",  64'(a_valid), 64'd0);

    // 3: simultaneous completions, round-robin vs fixed priority
    do_reset();
    cmd_ready = 1'b1;
    done = 2'b00;
    tick();
    data[0] = rand_wide(); data[1] = rand_wide();
    done = 2'b11;
    tick();
    wait_cmd("t3a_first", 1'b0, 1'b0);
    tick();
    wait_cmd("t3a_second", 1'b1, 1'b1);
    tick();
    complete(0, 1'b0, 8'h11, 8'h22);
    tick();
    wait_cmd("t3_single", 1'b0, 1'b0);
    tick();
    done = 2'b00;
    tick();
    data[0] = rand_wide(); data[1] = rand_wide();
    done = 2'b11;
    tick();
    wait_cmd("t3b_first", 1'b1, 1'b0);
    tick();
    wait_cmd("t3b_second", 1'b0, 1'b1);
    tick();

    // 4: consumer stalled while ch1 completes twice behind a ch0 command
    do_reset();
    cmd_ready = 1'b0;
    complete(0, 1'b0, 8'h03, 8'h30);
    repeat (6) tick();
    complete(1, 1'b0, 8'h04, 8'h41);
    repeat (6) tick();
    complete(1, 1'b0, 8'h09, 8'h42);
    frame2 = data[1];
    repeat (35) tick();
    check_value("t4_ovr1_a", 64'(a_ovr1), 64'd1);
    check_value("t4_ovr1_b", 64'(b_ovr1), 64'd1);
    cmd_ready = 1'b1;
    wait_cmd("t4_first", 1'b0, 1'b0);
    tick();
    wait_cmd("t4_second", 1'b1, 1'b1);
    check_value("t4_dlo",   a_data[63:0], frame2[63:0]);
    check_value("t4_dfold", fold(a_data), fold(frame2));
    check_value("t4_size",  64'(a_size),  64'd9);
    tick();

    // 5: error completions count and saturate, never present
    do_reset();
    for (int k = 0; k < 5; k++) begin
      complete(1, 1'b1, 8'h01, 8'hEE);
      repeat (4) begin
        tick();
        check_value("t5_novalid", 64'(a_valid), 64'd0);
      end
      if (k == 2) begin
        check_value("t5_err3_a", 64'(a_err1), 64'd3);
        check_value("t5_err3_b", 64'(b_err1), 64'd3);
      end
    end
    check_value("t5_err5_a", 64'(a_err1), 64'd5);
    check_value("t5_sat_b",  64'(b_err1), 64'd3);

    // 6: disabling a pending channel drops its request
    do_reset();
    cmd_ready = 1'b0;
    complete(1, 1'b0, 8'h07, 8'h70);
    repeat (5) tick();
    complete(0, 1'b0, 8'h08, 8'h80);
    tick();
    tick();
    ch_enable = 2'b10;
    tick();
    tick();
    ch_enable = 2'b11;
    cmd_ready = 1'b1;
    wait_cmd("t6_host", 1'b1, 1'b1);
    tick();
    seen_ble = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (a_valid) seen_ble++;
    end
    check_value("t6_no_ble", 64'(seen_ble), 64'd0);
    // reset while a command is being presented
    cmd_ready = 1'b0;
    complete(0, 1'b0, 8'h0A, 8'hAB);
    repeat (5) tick();
    check_value("t6_present", 64'(a_valid), 64'd1);
    do_reset();
    check_value("t6_rst_data", a_data[63:0], 64'd0);

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (done[c]) begin
          if ($urandom_range(0, 5) == 0) done[c] = 1'b0;
        end else if ($urandom_range(0, 1) == 0) begin
          data[c]  = rand_wide();
          size[c]  = 8'($urandom);
          error[c] = ($urandom_range(0, 4) == 0);
          done[c]  = 1'b1;
        end
      end
      cmd_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 49) == 0)      ch_enable = 2'($urandom);
      else if ($urandom_range(0, 19) == 0) ch_enable = 2'b11;
      if (k == 1000) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
